// File: rtl/rv_mem_arbiter_pkg.sv
// Shared types and defaults for the rv_pl unified-memory arbiter.
package rv_mem_arbiter_pkg;

  localparam int unsigned AW_DEF           = 32;
  localparam int unsigned DW_DEF           = 32;
  localparam int unsigned MAX_D_STREAK_DEF = 4;
  localparam int unsigned TIMEOUT_DEF      = 64;
  localparam logic [31:0] ERR_DATA_DEF     = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Bits needed to hold the values 0..max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rv_mem_arbiter_pick.sv
// Priority select between fetch and data requesters; data wins unless its
// consecutive-grant streak has starved a pending fetch.
module rv_mem_arbiter_pick
  import rv_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   sample,
  input  logic   i_req,
  input  logic   d_req,
  output logic   grant_valid,
  output owner_e grant_owner
);

  localparam int unsigned SW = cnt_w(MAX_D_STREAK);

  logic [SW-1:0] streak;
  logic          streak_full;

  // Combinational grant decision, only consumed while the FSM is idle.
  always_comb begin
    streak_full = (streak == SW'(MAX_D_STREAK));
    grant_valid = i_req | d_req;
    grant_owner = OWN_I;
    if (d_req && !(i_req && streak_full)) begin
      grant_owner = OWN_D;
    end
  end

  // Streak only grows while a fetch is being held off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (sample) begin
      if (!i_req || grant_owner == OWN_I) begin
        streak <= '0;
      end else begin
        streak <= streak + SW'(1);
      end
    end
  end

endmodule

// File: rtl/rv_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and data,
// with a watchdog that turns a hung memory into an error completion.
module rv_mem_arbiter
  import rv_mem_arbiter_pkg::*;
#(
  parameter int unsigned AW           = AW_DEF,
  parameter int unsigned DW           = DW_DEF,
  parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEF,
  parameter int unsigned TIMEOUT      = TIMEOUT_DEF,
  parameter logic [DW-1:0] ERR_DATA   = DW'(ERR_DATA_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic [DW-1:0]   i_rdata,
  output logic            i_done,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic [DW-1:0]   d_rdata,
  output logic            d_done,
  output logic            m_valid,
  output logic            m_we,
  output logic [DW/8-1:0] m_be,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic            m_ready,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata,
  output logic            busy,
  output logic            err
);

  localparam int unsigned BW  = DW / 8;
  localparam int unsigned WDW = cnt_w(TIMEOUT);

  state_e          state, state_nx;
  owner_e          own, own_nx;
  logic [WDW-1:0]  wd, wd_nx;
  logic            wd_expired;

  logic            m_valid_nx, m_we_nx;
  logic [BW-1:0]   m_be_nx;
  logic [AW-1:0]   m_addr_nx;
  logic [DW-1:0]   m_wdata_nx;
  logic [DW-1:0]   i_rdata_nx, d_rdata_nx, rdata_val;
  logic            i_done_nx, d_done_nx, err_nx;
  logic            complete, load_rdata, timeout;

  logic            grant_valid;
  owner_e          grant_owner;

  rv_mem_arbiter_pick #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_pick (
    .clk        (clk),
    .rst        (rst),
    .sample     (state == ST_IDLE),
    .i_req      (i_req),
    .d_req      (d_req),
    .grant_valid(grant_valid),
    .grant_owner(grant_owner)
  );

  // Next-state and next-output logic; the m_* registers double as the payload latch.
  always_comb begin
    state_nx   = state;
    own_nx     = own;
    wd_nx      = wd;
    m_valid_nx = m_valid;
    m_we_nx    = m_we;
    m_be_nx    = m_be;
    m_addr_nx  = m_addr;
    m_wdata_nx = m_wdata;
    i_rdata_nx = i_rdata;
    d_rdata_nx = d_rdata;
    i_done_nx  = 1'b0;
    d_done_nx  = 1'b0;
    err_nx     = err;
    complete   = 1'b0;
    load_rdata = 1'b0;
    timeout    = 1'b0;
    rdata_val  = m_rdata;
    wd_expired = (wd >= WDW'(TIMEOUT - 1));

    unique case (state)
      ST_IDLE: begin
        wd_nx = '0;
        if (grant_valid) begin
          own_nx     = grant_owner;
          state_nx   = ST_ISSUE;
          m_valid_nx = 1'b1;
          if (grant_owner == OWN_D) begin
            m_we_nx    = d_we;
            m_be_nx    = d_be;
            m_addr_nx  = d_addr;
            m_wdata_nx = d_wdata;
          end else begin
            m_we_nx    = 1'b0;
            m_be_nx    = '0;
            m_addr_nx  = i_addr;
            m_wdata_nx = '0;
          end
        end
      end
      ST_ISSUE: begin
        wd_nx = wd + WDW'(1);
        if (m_valid && m_ready) begin
          m_valid_nx = 1'b0;
          if (m_we) begin
            state_nx = ST_DONE;
            complete = 1'b1;
          end else begin
            state_nx = ST_WAIT_R;
          end
        end else if (wd_expired) begin
          timeout = 1'b1;
        end
      end
      ST_WAIT_R: begin
        wd_nx = wd + WDW'(1);
        if (m_rvalid) begin
          state_nx   = ST_DONE;
          complete   = 1'b1;
          load_rdata = 1'b1;
        end else if (wd_expired) begin
          timeout = 1'b1;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    // Watchdog: abandon the command and complete with error data.
    if (timeout) begin
      m_valid_nx = 1'b0;
      err_nx     = 1'b1;
      state_nx   = ST_DONE;
      complete   = 1'b1;
      load_rdata = !m_we;
      rdata_val  = ERR_DATA;
    end

    if (complete) begin
      if (own == OWN_D) begin
        d_done_nx = 1'b1;
        if (load_rdata) begin
          d_rdata_nx = rdata_val;
        end
      end else begin
        i_done_nx = 1'b1;
        if (load_rdata) begin
          i_rdata_nx = rdata_val;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      own     <= OWN_I;
      wd      <= '0;
      m_valid <= 1'b0;
      m_we    <= 1'b0;
      m_be    <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      own     <= own_nx;
      wd      <= wd_nx;
      m_valid <= m_valid_nx;
      m_we    <= m_we_nx;
      m_be    <= m_be_nx;
      m_addr  <= m_addr_nx;
      m_wdata <= m_wdata_nx;
      i_rdata <= i_rdata_nx;
      d_rdata <= d_rdata_nx;
      i_done  <= i_done_nx;
      d_done  <= d_done_nx;
      busy    <= (state_nx != ST_IDLE);
      err     <= err_nx;
    end
  end

endmodule
